ahb_seven_segment: RTL and testbench
====================================

Name: ahb_seven_segment

Overview:
AHB-Lite slave that drives a 4-digit, multiplexed, common-anode seven-segment display. It is the output-side counterpart of the switch/button input slave on the M0 AHB-Lite system bus. The bus master writes a 16-bit hex value, per-digit enables and decimal points. The block scans the digits autonomously and reports an update flag. It has single-cycle, zero-wait-state transfers, and only 32-bit word transfers are supported (HSIZE is ignored).

Parameters:
REFRESH_DIV, 16384, HCLK cycles per digit slot; legal range 2..65536.

Ports:
HCLK  input  1  AHB clock; all state changes on its rising edge
HRESETn  input  1  asynchronous, active-low reset
HADDR  input  32  only HADDR[3:2] is decoded
HWDATA  input  32  write data, sampled in the data phase
HSIZE  input  3  ignored
HTRANS  input  2  transfer type; 2'b00 (IDLE) means no transfer
HWRITE  input  1  1 = write
HREADY  input  1  bus ready
HSEL  input  1  slave select
HRDATA  output  32  read data
HREADYOUT  output  1  tied to 1
nDigit  output  4  active-low digit anode drive; nDigit[0] is the rightmost digit
nSegment  output  7  active-low segments; bit 0 = a .. bit 6 = g
nDP  output  1  active-low decimal point

Behaviour:
- Address map (base + offset):
  - +0 Value: R/W; [15:0] holds four hex nibbles; nibble k shows on digit k; [31:16] reads 0.
  - +4 Control: R/W; [3:0] DigitEnable, [7:4] DPEnable; other bits read 0.
  - +8 Status: read-only; bit 0 = Updated; writes are ignored.
  - +12: reads 0; writes are ignored.
- Address phase: when HREADY && HSEL && HTRANS != IDLE, register write_enable = HWRITE, read_enable = !HWRITE, and word_address = HADDR[3:2]. Otherwise clear all three to 0.
- Data-phase write: on the rising edge that ends the data phase, load HWDATA into the addressed register. Unused bits are discarded.
- Data-phase read: HRDATA is combinational from the addressed register, and is 0 when read_enable = 0.
- Updated flag:
  - Set by a write to +0.
  - Cleared in the cycle the master completes a read of +8.
  - A set and a clear never coincide because each data phase carries one transfer.
- Prescaler: counter slot_cnt runs 0..REFRESH_DIV-1. When it reaches REFRESH_DIV-1 it wraps to 0 and digit_sel (2 bits) increments 0→1→2→3→0.
- Output stage: registered, with one cycle latency from digit_sel, Value and Control.
  - nDigit = ~(onehot(digit_sel) & DigitEnable).
  - nSegment = hexdecode(Value nibble[digit_sel]).
  - nDP = ~DPEnable[digit_sel].
  - A disabled digit still receives its segment pattern but its anode stays off.
- Hex decode, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Write-to-display latency: a write at edge N changes the register at N. The outputs reflect it at edge N+1 if that digit is currently selected.
- Reset (asynchronous, any time, including mid-transfer or mid-slot):
  - Value, Control, Updated, slot_cnt, digit_sel, write_enable, read_enable and word_address all go to 0.
  - nDigit = 4'b1111, nSegment = 7'b1111111, nDP = 1, HRDATA = 0.
  - An in-flight write is lost.

Optional Feature:
Macro SEVEN_SEGMENT_BLANKING_EN (anti-ghosting blanking).
- Defined: while slot_cnt < 16, nDigit is forced to 4'b1111 and nDP to 1. Segments still update at the slot boundary. REFRESH_DIV must be > 16.
- Undefined: no blanking; the digit drives for the whole slot.

Test Plan:
1. Reset check (REFRESH_DIV = 8): hold HRESETn low → nDigit = 1111, nSegment = 1111111, nDP = 1. Read +0, +4 and +8 → each returns 0.
2. Write/readback and decode:
   - Write +0 = 0x0000_12AF, then +4 = 0x0000_001F.
   - Readback: +0 returns 0x12AF, +4 returns 0x1F, +8 returns 1.
   - Digit 0 slot: nDigit = 1110, nSegment = 0001110, nDP = 0.
   - Digit 3 slot: nSegment = 1111001, nDP = 1.
3. Scan timing (REFRESH_DIV = 8): check the nDigit sequence 1110→1101→1011→0111→1110, with each value held exactly 8 cycles.
4. Updated flag: write +0 = 0x8 → read +8 returns 1. A second read of +8 returns 0. A write to +8 leaves the flag unchanged.
5. Back-to-back pipelined traffic: write +0 = 0x1234 immediately followed by a read of +0 → the read returns 0x1234 with HREADYOUT = 1 throughout. A write to +12 changes nothing.
6. Mid-operation reset: assert HRESETn during a write data phase to +0 → Value stays 0 and the outputs go blank. After release, the scan restarts at digit 0. With SEVEN_SEGMENT_BLANKING_EN and REFRESH_DIV = 32, nDigit = 1111 for the first 16 cycles of each slot.

Source files
------------

// File: rtl/ahb_seven_segment.sv
// AHB-Lite slave driving a 4-digit multiplexed common-anode seven-segment display.
// Optional anti-ghosting blanking: define SEVEN_SEGMENT_BLANKING_EN.
module ahb_seven_segment #(
  parameter int REFRESH_DIV = 16384
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [3:0]  nDigit,
  output logic [6:0]  nSegment,
  output logic        nDP
);

  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

  logic        write_enable;
  logic        read_enable;
  logic [1:0]  word_address;
  logic        addr_valid;
  logic [15:0] value;
  logic [7:0]  control;
  logic        updated;
  logic [15:0] slot_cnt;
  logic [1:0]  digit_sel;
  logic [3:0]  nibble;
  logic [3:0]  onehot;
  logic [6:0]  seg_next;
  logic        blank;
  logic        unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};
  assign HREADYOUT   = 1'b1;
  assign addr_valid  = HREADY & HSEL & (HTRANS != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      word_address <= 2'd0;
    end else if (addr_valid) begin
      write_enable <= HWRITE;
      read_enable  <= ~HWRITE;
      word_address <= HADDR[3:2];
    end else begin
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      word_address <= 2'd0;
    end
  end

  // Each data phase carries one transfer, so set and clear never collide.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      value   <= 16'd0;
      control <= 8'd0;
      updated <= 1'b0;
    end else if (write_enable) begin
      case (word_address)
        2'd0: begin
          value   <= HWDATA[15:0];
          updated <= 1'b1;
        end
        2'd1: control <= HWDATA[7:0];
        default: ;
      endcase
    end else if (read_enable && word_address == 2'd2) begin
      updated <= 1'b0;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (read_enable) begin
      case (word_address)
        2'd0: HRDATA[15:0] = value;
        2'd1: HRDATA[7:0]  = control;
        2'd2: HRDATA[0]    = updated;
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      slot_cnt  <= 16'd0;
      digit_sel <= 2'd0;
    end else if (slot_cnt == LAST) begin
      slot_cnt  <= 16'd0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      slot_cnt  <= slot_cnt + 16'd1;
    end
  end

  assign nibble = value[{digit_sel, 2'b00} +: 4];
  assign onehot = 4'b0001 << digit_sel;

  always_comb begin
    case (nibble)
      4'h0: seg_next = 7'b1000000;
      4'h1: seg_next = 7'b1111001;
      4'h2: seg_next = 7'b0100100;
      4'h3: seg_next = 7'b0110000;
      4'h4: seg_next = 7'b0011001;
      4'h5: seg_next = 7'b0010010;
      4'h6: seg_next = 7'b0000010;
      4'h7: seg_next = 7'b1111000;
      4'h8: seg_next = 7'b0000000;
      4'h9: seg_next = 7'b0010000;
      4'hA: seg_next = 7'b0001000;
      4'hB: seg_next = 7'b0000011;
      4'hC: seg_next = 7'b1000110;
      4'hD: seg_next = 7'b0100001;
      4'hE: seg_next = 7'b0000110;
      default: seg_next = 7'b0001110;
    endcase
  end

`ifdef SEVEN_SEGMENT_BLANKING_EN
  // Anodes stay dark at the start of each slot so segments settle first.
  assign blank = slot_cnt < 16'd16;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      nDigit   <= 4'b1111;
      nSegment <= 7'b1111111;
      nDP      <= 1'b1;
    end else begin
      nSegment <= seg_next;
      nDigit   <= blank ? 4'b1111 : ~(onehot & control[3:0]);
      nDP      <= blank ? 1'b1 : ~control[4 + digit_sel];
    end
  end

endmodule

// File: tb/tb_ahb_seven_segment.sv
// Scoreboard bench for ahb_seven_segment: bus reads, scan timing, flag, reset.
module tb_ahb_seven_segment;

`ifdef SEVEN_SEGMENT_BLANKING_EN
  localparam int DIV = 32;
`else
  localparam int DIV = 8;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HSIZE = 3'b010;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic        HREADY = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [3:0]  nDigit;
  logic [6:0]  nSegment;
  logic        nDP;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  string       nm_q[$];
  logic [3:0]  seq_q[$];

  ahb_seven_segment #(.REFRESH_DIV(DIV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .nDigit(nDigit), .nSegment(nSegment), .nDP(nDP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR = a;
  endtask

  task automatic no_addr();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(1'b1, a);
    tick();
    no_addr();
    HWDATA = d;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] e,
                         input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    addr_phase(1'b0, a);
    tick();
    no_addr();
    act_q.push_back(HRDATA);
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] e, a;
    string n;
    HRESETn = 1'b0;
    repeat (3) tick();
    total++;
    if (nDigit !== 4'b1111) begin
      bad++;
      $display("FAIL rst_digit got=%b want=1111", nDigit);
    end
    total++;
    if (nSegment !== 7'b1111111) begin
      bad++;
      $display("FAIL rst_seg got=%b want=1111111", nSegment);
    end
    total++;
    if (nDP !== 1'b1 || HRDATA !== 32'd0) begin
      bad++;
      $display("FAIL rst_dp_rdata dp=%b rdata=%h want 1/0", nDP, HRDATA);
    end
    HRESETn = 1'b1;
    tick();
    do_read(32'h0, 32'h0, "rst_value");
    do_read(32'h4, 32'h0, "rst_ctrl");
    do_read(32'h8, 32'h0, "rst_status");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = act_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, e);
      end
    end
  endtask

  task automatic test_write_decode();
    logic [31:0] e, a;
    string n;
    int g;
    do_write(32'h0, 32'h0000_12AF);
    do_write(32'h4, 32'h0000_001F);
    do_read(32'h0, 32'h0000_12AF, "rb_value");
    do_read(32'h4, 32'h0000_001F, "rb_ctrl");
    do_read(32'h8, 32'h1, "rb_status");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = act_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, e);
      end
    end
    g = 0;
    while (nDigit !== 4'b1110 && g < 10 * DIV) begin
      tick();
      g++;
    end
    total++;
    if (nSegment !== 7'b0001110 || nDP !== 1'b0) begin
      bad++;
      $display("FAIL dig0 dg=%b seg=%b dp=%b want 1110/0001110/0",
               nDigit, nSegment, nDP);
    end
    g = 0;
    while (nDigit !== 4'b0111 && g < 10 * DIV) begin
      tick();
      g++;
    end
    total++;
    if (nSegment !== 7'b1111001 || nDP !== 1'b1) begin
      bad++;
      $display("FAIL dig3 dg=%b seg=%b dp=%b want 0111/1111001/1",
               nDigit, nSegment, nDP);
    end
  endtask

  task automatic test_scan();
    logic [3:0] prev, cur, e;
    int cnt, g;
    seq_q = {4'b1101, 4'b1011, 4'b0111, 4'b1110};
    g = 0;
    do begin
      prev = nDigit;
      tick();
      g++;
    end while (!(prev !== 4'b1110 && nDigit === 4'b1110) && g < 10 * DIV);
    total++;
    if (nDigit !== 4'b1110) begin
      bad++;
      $display("FAIL scan_sync got=%b want=1110", nDigit);
    end
    cur = nDigit;
    cnt = 1;
    g = 0;
    while (seq_q.size() > 0 && g < 10 * DIV) begin
      tick();
      g++;
      if (nDigit === cur) cnt++;
      else begin
        e = seq_q.pop_front();
        total++;
        if (nDigit !== e || cnt != DIV) begin
          bad++;
          $display("FAIL scan_step got=%b held=%0d want=%b held=%0d",
                   nDigit, cnt, e, DIV);
        end
        cur = nDigit;
        cnt = 1;
      end
    end
    total++;
    if (seq_q.size() != 0) begin
      bad++;
      $display("FAIL scan_timeout left=%0d want=0", seq_q.size());
      seq_q.delete();
    end
  endtask

  task automatic test_updated();
    logic [31:0] e, a;
    string n;
    do_write(32'h0, 32'h8);
    do_read(32'h8, 32'h1, "upd_set");
    do_read(32'h8, 32'h0, "upd_clear");
    do_write(32'h0, 32'h8);
    do_write(32'h8, 32'h0);
    do_read(32'h8, 32'h1, "upd_wr_status");
    do_read(32'h0, 32'h8, "upd_value");
    do_read(32'h8, 32'h0, "upd_clear2");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = act_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, a;
    string n;
    addr_phase(1'b1, 32'h0);
    tick();
    total++;
    if (HREADYOUT !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready1 got=%b want=1", HREADYOUT);
    end
    HWDATA = 32'h0000_1234;
    addr_phase(1'b0, 32'h0);
    exp_q.push_back(32'h0000_1234);
    nm_q.push_back("b2b_read");
    tick();
    no_addr();
    total++;
    if (HREADYOUT !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready2 got=%b want=1", HREADYOUT);
    end
    act_q.push_back(HRDATA);
    tick();
    do_read(32'h8, 32'h1, "b2b_status");
    do_write(32'hC, 32'hFFFF_FFFF);
    do_read(32'h0, 32'h0000_1234, "w12_value");
    do_read(32'h4, 32'h0000_001F, "w12_ctrl");
    do_read(32'h8, 32'h0, "w12_status");
    do_read(32'hC, 32'h0, "w12_read");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = act_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] e, a;
    logic [3:0]  dexp;
    string n;
    addr_phase(1'b1, 32'h0);
    tick();
    no_addr();
    HWDATA = 32'h0000_ABCD;
    #2 HRESETn = 1'b0;
    #1;
    total++;
    if (nDigit !== 4'b1111 || nSegment !== 7'b1111111 || nDP !== 1'b1) begin
      bad++;
      $display("FAIL mid_blank dg=%b seg=%b dp=%b want 1111/1111111/1",
               nDigit, nSegment, nDP);
    end
    total++;
    if (HRDATA !== 32'd0) begin
      bad++;
      $display("FAIL mid_rdata got=%h want=0", HRDATA);
    end
    tick();
    tick();
    HRESETn = 1'b1;
    do_write(32'h4, 32'h0000_000F);
    tick();
`ifdef SEVEN_SEGMENT_BLANKING_EN
    dexp = 4'b1111;
`else
    dexp = 4'b1110;
`endif
    total++;
    if (nDigit !== dexp || nSegment !== 7'b1000000) begin
      bad++;
      $display("FAIL mid_restart dg=%b seg=%b want %b/1000000",
               nDigit, nSegment, dexp);
    end
    do_read(32'h0, 32'h0, "mid_value");
    do_read(32'h8, 32'h0, "mid_status");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = act_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, e);
      end
    end
  endtask

`ifdef SEVEN_SEGMENT_BLANKING_EN
  task automatic test_blanking();
    logic [3:0] prev;
    int g, nb, na;
    g = 0;
    do begin
      prev = nDigit;
      tick();
      g++;
    end while (!(prev !== 4'b1111 && nDigit === 4'b1111) && g < 10 * DIV);
    for (int s = 0; s < 2; s++) begin
      nb = 0;
      while (nDigit === 4'b1111 && nb < 2 * DIV) begin
        tick();
        nb++;
      end
      na = 0;
      while (nDigit !== 4'b1111 && na < 2 * DIV) begin
        tick();
        na++;
      end
      total++;
      if (nb != 16 || na != DIV - 16) begin
        bad++;
        $display("FAIL blank_slot blank=%0d lit=%0d want 16/%0d",
                 nb, na, DIV - 16);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_decode();
`ifdef SEVEN_SEGMENT_BLANKING_EN
    test_blanking();
`else
    test_scan();
`endif
    test_updated();
    test_back_to_back();
    test_mid_reset();
`ifdef SEVEN_SEGMENT_BLANKING_EN
    test_blanking();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
